// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and opcode helpers for alu_seq_logical (honours ALU_ROTATE_EN)
package alu_seq_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_ROL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ops that go through the iterative shifter; ROL only exists when rotate is built in.
  function automatic logic is_shift_op(input logic [2:0] op);
`ifdef ALU_ROTATE_EN
    return op[2];
`else
    return op[2] && (op != OP_ROL);
`endif
  endfunction

  // The only undecodable opcode is the upper-half one that is not a shift.
  function automatic logic is_illegal_op(input logic [2:0] op);
    return op[2] && !is_shift_op(op);
  endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// rtl/alu_logic_unit.sv - combinational AND/OR/XOR/NOR on latched operands
module alu_logic_unit #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Select among the four bitwise functions by the low opcode bits.
  always_comb begin
    y = '0;
    case (sel)
      2'b00:   y = a & b;
      2'b01:   y = a | b;
      2'b10:   y = a ^ b;
      default: y = ~(a | b);
    endcase
  end

endmodule

// File: rtl/alu_seq_logical.sv
// rtl/alu_seq_logical.sv - handshaked logical/iterative-shift unit; ALU_ROTATE_EN adds ROL on opcode 111
module alu_seq_logical
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W:0] STEP = (SHAMT_W + 1)'(SHIFT_STEP);

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   b_q;
  logic [SHAMT_W-1:0] count;
  logic [SHAMT_W:0]   amt;
  logic [WIDTH-1:0]   shift_res;
  logic [WIDTH-1:0]   logic_res;
  logic               accept;
  logic [SHAMT_W-1:0] shamt_in;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign shamt_in  = in2[SHAMT_W-1:0];

  // acc still holds the latched in1 for logical ops, so it doubles as operand A.
  alu_logic_unit #(.WIDTH(WIDTH)) u_logic (
    .sel (op_q[1:0]),
    .a   (acc),
    .b   (b_q),
    .y   (logic_res)
  );

`ifdef ALU_ROTATE_EN
  logic [2*WIDTH-1:0] rol_dbl;
  assign rol_dbl = {acc, acc} << amt;
`endif

  // One shift step: move by min(SHIFT_STEP, remaining count).
  always_comb begin
    amt       = ({1'b0, count} >= STEP) ? STEP : {1'b0, count};
    shift_res = acc;
    case (op_q)
      OP_SRA:  shift_res = $signed(acc) >>> amt;
      OP_SRL:  shift_res = acc >> amt;
      OP_SLL:  shift_res = acc << amt;
`ifdef ALU_ROTATE_EN
      OP_ROL:  shift_res = rol_dbl[2*WIDTH-1:WIDTH];
`endif
      default: shift_res = acc;
    endcase
  end

  // Next-state: shifts with a non-zero amount iterate, everything else goes straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = (is_shift_op(in_op) && (shamt_in != '0)) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if ({1'b0, count} <= STEP) state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Operand capture at accept, then accumulate shift steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_AND;
      acc   <= '0;
      b_q   <= '0;
      count <= '0;
    end else if (accept) begin
      op_q  <= in_op;
      acc   <= in1;
      b_q   <= in2;
      count <= is_shift_op(in_op) ? shamt_in : '0;
    end else if (state == ST_SHIFT) begin
      acc   <= shift_res;
      count <= count - amt[SHAMT_W-1:0];
    end
  end

  // Result only presented in DONE so reset/idle show zero.
  always_comb begin
    out_err  = out_valid && is_illegal_op(op_q);
    out_data = '0;
    if (out_valid && !is_illegal_op(op_q))
      out_data = is_shift_op(op_q) ? acc : logic_res;
  end

endmodule

// File: tb/tb_alu_seq_logical.sv
// tb/tb_alu_seq_logical.sv - directed self-checking bench for alu_seq_logical (ALU_ROTATE_EN aware)
module tb_alu_seq_logical;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  alu_seq_logical #(.WIDTH(32), .SHIFT_STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Wait for in_ready, present one op, return #1 after the accepting edge with inputs scrambled.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (!in_ready && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("issue_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in1      = a;
    in2      = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op    = ~op;
    in1      = 32'hDEAD_BEEF;
    in2      = 32'h1234_5677;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic exp_err,
                        input int exp_lat);
    int lat;
    issue(op, a, b);
    wait_valid(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in1 = '0; in2 = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_err", {31'd0, out_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    run_op("and",      3'b000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
    run_op("or",       3'b001, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1);
    run_op("xor",      3'b010, 32'hFFFF_0000, 32'h0FF0_0FF0, 32'hF00F_0FF0, 1'b0, 1);
    run_op("nor",      3'b011, 32'h0000_FFFF, 32'h00FF_0000, 32'hFF00_0000, 1'b0, 1);
    run_op("sll4",     3'b110, 32'h0000_0030, 32'd4,         32'h0000_0300, 1'b0, 2);
    run_op("sra31",    3'b100, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 9);
    run_op("srl31",    3'b101, 32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, 9);
    run_op("srl0",     3'b101, 32'h0000_000A, 32'd0,         32'h0000_000A, 1'b0, 1);
    run_op("sra_pos",  3'b100, 32'h7000_0000, 32'd5,         32'h0380_0000, 1'b0, 3);
    run_op("sra_neg",  3'b100, 32'hF000_0000, 32'd8,         32'hFFF0_0000, 1'b0, 3);
    run_op("sll_mod",  3'b110, 32'h0000_0001, 32'hFFFF_FF21, 32'h0000_0002, 1'b0, 2);
    run_op("sll31",    3'b110, 32'h0000_0001, 32'd31,        32'h8000_0000, 1'b0, 9);
`ifdef ALU_ROTATE_EN
    run_op("rol",      3'b111, 32'h8000_0001, 32'd1,         32'h0000_0003, 1'b0, 2);
`else
    run_op("illegal",  3'b111, 32'h8000_0001, 32'd1,         32'h0000_0000, 1'b1, 1);
`endif

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue(3'b010, 32'h1, 32'h0);
    wait_valid(lat);
    check("bp_lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", out_data, 32'h1);
      check("bp_busy", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {31'd0, in_ready}, 32'd1);

    // Reset while shifting.
    issue(3'b110, 32'h1, 32'd28);
    @(posedge clk); #1;
    check("mid_busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("post_rst", 3'b000, 32'h0000_00FF, 32'h0000_000F, 32'h0000_000F, 1'b0, 1);

    // Reset while a result is waiting.
    out_ready = 1'b0;
    issue(3'b001, 32'h12, 32'h34);
    wait_valid(lat);
    check("done_data", out_data, 32'h36);
    rst_n = 1'b0;
    #1;
    check("done_rst_valid", {31'd0, out_valid}, 32'd0);
    check("done_rst_data", out_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    run_op("final", 3'b101, 32'hF000_0000, 32'd4, 32'h0F00_0000, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
